// File: rtl/mem_request_queue.sv
// In-order request queue between the trace parser and the DRAM command scheduler.
// Entries carry {opcode, address, age}; the oldest entry is offered through a valid/ready handshake.
module mem_request_queue #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DEPTH         = 16,
  parameter int AGE_WIDTH     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 opcode,
  input  logic [ADDRESS_WIDTH-1:0]   address,
  output logic                       op_ready_s,
  output logic                       req_valid,
  output logic [1:0]                 req_opcode,
  output logic [ADDRESS_WIDTH-1:0]   req_address,
  output logic [AGE_WIDTH-1:0]       req_age,
  input  logic                       req_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

  typedef enum logic [1:0] {
    OP_READ   = 2'd0,
    OP_WRITE  = 2'd1,
    OP_IFETCH = 2'd2,
    OP_NOP    = 2'd3
  } opcode_e;

  logic [1:0]               opcode_mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] addr_mem   [DEPTH];
  logic [AGE_WIDTH-1:0]     age_mem    [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [DEPTH-1:0] entry_valid;
  logic             push;
  logic             pop;

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign req_valid  = ~empty;
  assign op_ready_s = ~rst & ~full;
  assign push       = op_ready_s & (opcode != OP_NOP);
  assign pop        = req_valid & req_ready;

  // An entry is live when its distance from the head is below the occupancy.
  always_comb begin
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = ({1'b0, PTR_W'(PTR_W'(i) - rd_ptr)} < count);
    end
  end

  // NOTE: every output gets a default before the conditional, so no latch can be inferred.
  always_comb begin
    req_opcode  = '0;
    req_address = '0;
    req_age     = '0;
    if (req_valid) begin
      req_opcode  = opcode_mem[rd_ptr];
      req_address = addr_mem[rd_ptr];
      req_age     = age_mem[rd_ptr];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) age_mem[i] <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (PTR_W'(i) == wr_ptr)) begin
          age_mem[i] <= '0;
        end else if (entry_valid[i] && (age_mem[i] != AGE_MAX)) begin
          age_mem[i] <= age_mem[i] + 1'b1;
        end
      end
    end
  end

  // NOTE: payload storage is deliberately left out of reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      opcode_mem[wr_ptr] <= opcode;
      addr_mem[wr_ptr]   <= address;
    end
  end

  push_while_full : assert property (@(posedge clk) disable iff (rst) !(push && (count == CNT_W'(DEPTH))))
    else $error("push while queue full");
  pop_while_empty : assert property (@(posedge clk) disable iff (rst) !(pop && (count == '0)))
    else $error("pop while queue empty");

endmodule

// File: tb/tb_mem_request_queue.sv
// Scoreboard bench for mem_request_queue: stimulus queues expected dequeues, a monitor
// compares every handshake; directed checks cover reset, flow control, age and wrap.
module tb_mem_request_queue;

  localparam int AW  = 32;
  localparam int DEP = 16;
  localparam int AGW = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     opcode;
  logic [AW-1:0]  address;
  logic           op_ready_s;
  logic           req_valid;
  logic [1:0]     req_opcode;
  logic [AW-1:0]  req_address;
  logic [AGW-1:0] req_age;
  logic           req_ready;
  logic [4:0]     count;
  logic           full;
  logic           empty;

  typedef struct packed {
    logic [1:0]    op;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  mem_request_queue #(.ADDRESS_WIDTH(AW), .DEPTH(DEP), .AGE_WIDTH(AGW)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .address    (address),
    .op_ready_s (op_ready_s),
    .req_valid  (req_valid),
    .req_opcode (req_opcode),
    .req_address(req_address),
    .req_age    (req_age),
    .req_ready  (req_ready),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic drive_push(input logic [1:0] op, input logic [AW-1:0] addr);
    opcode  = op;
    address = addr;
    exp_q.push_back('{op: op, addr: addr});
  endtask

  // Monitor: every accepted handshake must match the oldest expected request.
  always @(negedge clk) begin
    if (req_valid === 1'b1 && req_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_dequeue", {32'd0, req_address}, 64'hdead);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("deq_opcode", 64'(req_opcode), 64'(e.op));
        check("deq_address", 64'(req_address), 64'(e.addr));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    rst = 1'b1; opcode = 2'd3; address = '0; req_ready = 1'b0;

    // Reset held for three edges
    repeat (3) cyc();
    settle();
    check("rst_op_ready", 64'(op_ready_s), 64'd0);
    check("rst_req_valid", 64'(req_valid), 64'd0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_full", 64'(full), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_req_address", 64'(req_address), 64'd0);
    check("rst_req_age", 64'(req_age), 64'd0);

    // Release reset and offer a single READ in the same cycle
    cyc();
    rst = 1'b0;
    drive_push(2'd0, 32'h1234_5678);
    settle();
    check("release_op_ready", 64'(op_ready_s), 64'd1);
    check("release_count", 64'(count), 64'd0);
    check("release_req_valid", 64'(req_valid), 64'd0);
    cyc();
    opcode = 2'd3;
    settle();
    check("single_valid", 64'(req_valid), 64'd1);
    check("single_opcode", 64'(req_opcode), 64'd0);
    check("single_address", 64'(req_address), 64'h1234_5678);
    check("single_age0", 64'(req_age), 64'd0);
    check("single_count", 64'(count), 64'd1);
    repeat (5) cyc();
    settle();
    check("single_age5", 64'(req_age), 64'd5);
    cyc();
    req_ready = 1'b1;
    cyc();
    req_ready = 1'b0;
    settle();
    check("single_drained", 64'(empty), 64'd1);

    // NOP is never enqueued
    opcode = 2'd3;
    address = 32'hffff_0000;
    for (int k = 0; k < 10; k++) begin
      cyc();
      settle();
      check("nop_count", 64'(count), 64'd0);
      check("nop_valid", 64'(req_valid), 64'd0);
    end

    // Fill with 16 WRITEs, then a 17th drive that must be ignored
    for (int k = 0; k < 16; k++) begin
      cyc();
      drive_push(2'd1, 32'(k));
    end
    cyc();
    opcode = 2'd1;
    address = 32'h10;
    settle();
    check("fill_full", 64'(full), 64'd1);
    check("fill_op_ready", 64'(op_ready_s), 64'd0);
    check("fill_count", 64'(count), 64'd16);
    cyc();
    opcode = 2'd3;
    settle();
    check("extra_ignored_count", 64'(count), 64'd16);
    check("head_oldest", 64'(req_address), 64'h0);
    cyc();
    req_ready = 1'b1;
    cyc();
    req_ready = 1'b0;
    settle();
    check("after_pop_count", 64'(count), 64'd15);
    check("after_pop_op_ready", 64'(op_ready_s), 64'd1);
    check("after_pop_full", 64'(full), 64'd0);
    check("after_pop_head", 64'(req_address), 64'h1);

    // Drain to 8 entries, then push and pop together across pointer wrap
    cyc();
    req_ready = 1'b1;
    repeat (7) cyc();
    req_ready = 1'b0;
    settle();
    check("pre_stream_count", 64'(count), 64'd8);
    check("pre_stream_head", 64'(req_address), 64'h8);
    for (int k = 0; k < 20; k++) begin
      cyc();
      req_ready = 1'b1;
      drive_push(2'd2, 32'h100 + 32'(k));
      settle();
      check("stream_count", 64'(count), 64'd8);
    end
    cyc();
    opcode = 2'd3;
    req_ready = 1'b0;
    settle();
    check("post_stream_count", 64'(count), 64'd8);
    check("post_stream_head", 64'(req_address), 64'h10c);
    cyc();
    req_ready = 1'b1;
    repeat (8) cyc();
    req_ready = 1'b0;
    settle();
    check("stream_drained", 64'(empty), 64'd1);

    // Age saturates instead of wrapping
    cyc();
    drive_push(2'd0, 32'h0000_aaaa);
    cyc();
    opcode = 2'd3;
    repeat (300) cyc();
    settle();
    check("age_saturated", 64'(req_age), 64'd255);
    check("age_head_address", 64'(req_address), 64'h0000_aaaa);

    // Mid-run reset discards the held entry
    cyc();
    rst = 1'b1;
    exp_q.delete();
    cyc();
    settle();
    check("midrst_op_ready", 64'(op_ready_s), 64'd0);
    check("midrst_valid", 64'(req_valid), 64'd0);
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_empty", 64'(empty), 64'd1);
    check("midrst_age", 64'(req_age), 64'd0);
    cyc();
    rst = 1'b0;
    drive_push(2'd1, 32'h0000_beef);
    cyc();
    opcode = 2'd3;
    settle();
    check("post_rst_head", 64'(req_address), 64'h0000_beef);
    check("post_rst_age", 64'(req_age), 64'd0);
    check("post_rst_count", 64'(count), 64'd1);
    cyc();
    req_ready = 1'b1;
    cyc();
    req_ready = 1'b0;
    settle();
    check("final_empty", 64'(empty), 64'd1);
    check("scoreboard_left", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
